// File: rtl/float_mul_arb_pkg.sv
// Shared types and FP format constants for the float multiplier arbiter.
// The enum encoding and the grant-width helper are common to the top and the arbiter.
package float_mul_arb_pkg;

    localparam int float_exp_width  = 8;
    localparam int float_mant_width = 23;
    localparam int float_width      = 1 + float_exp_width + float_mant_width;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } e_arb_state;

    // A single client still needs a 1-bit index so the vectors stay legal.
    function automatic int grant_idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from last_grant+1, wrapping.
// Zero latency; no backpressure, the caller decides when to consume the grant.
module rr_arbiter
    import float_mul_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int GW          = grant_idx_width(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] req_i,
    input  logic [GW-1:0]          last_grant_i,
    output logic [GW-1:0]          grant_o,
    output logic                   any_req_o
);

    logic          found;
    logic [GW-1:0] cand;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        cand    = '0;
        // Offset 1..N puts last_grant itself at the lowest priority.
        for (int i = 1; i <= NUM_CLIENTS; i++) begin
            cand = GW'((int'(last_grant_i) + i) % NUM_CLIENTS);
            if (!found && req_i[cand]) begin
                grant_o = cand;
                found   = 1'b1;
            end
        end
        any_req_o = |req_i;
    end

endmodule

// File: rtl/float_mul_arbiter.sv
// Shares one float multiplier among NUM_CLIENTS clients, one transaction at a time; ack = mul latency + 2.
// Clients hold req until their one-cycle ack; optional WAIT timeout via FLOAT_MUL_ARB_TIMEOUT_EN.
module float_mul_arbiter
    import float_mul_arb_pkg::*;
#(
    parameter int NUM_CLIENTS    = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CLIENTS-1:0]             cli_req,
    input  logic [NUM_CLIENTS*float_width-1:0] cli_a,
    input  logic [NUM_CLIENTS*float_width-1:0] cli_b,
    output logic [NUM_CLIENTS-1:0]             cli_ack,
    output logic [float_width-1:0]             cli_out,
    output logic                               cli_err,
    output logic                               mul_req,
    output logic [float_width-1:0]             mul_a,
    output logic [float_width-1:0]             mul_b,
    input  logic                               mul_ack,
    input  logic [float_width-1:0]             mul_out
);

    localparam int GW = grant_idx_width(NUM_CLIENTS);

    e_arb_state             state_q, state_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [GW-1:0]          last_grant_q, last_grant_d;
    logic                   mul_req_q, mul_req_d;
    logic [float_width-1:0] mul_a_q, mul_a_d;
    logic [float_width-1:0] mul_b_q, mul_b_d;
    logic [NUM_CLIENTS-1:0] cli_ack_q, cli_ack_d;
    logic [float_width-1:0] cli_out_q, cli_out_d;
    logic                   cli_err_q, cli_err_d;

    logic [GW-1:0] arb_grant;
    logic          arb_any;

    rr_arbiter #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .GW          (GW)
    ) u_rr (
        .req_i        (cli_req),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .any_req_o    (arb_any)
    );

`ifdef FLOAT_MUL_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_hit;

    assign tmo_hit = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_cnt_q <= '0;
        else     tmo_cnt_q <= tmo_cnt_d;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_CLIENTS - 1);
            mul_req_q    <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            cli_ack_q    <= '0;
            cli_out_q    <= '0;
            cli_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            mul_req_q    <= mul_req_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            cli_ack_q    <= cli_ack_d;
            cli_out_q    <= cli_out_d;
            cli_err_q    <= cli_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        mul_req_d    = 1'b0;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        cli_ack_d    = cli_ack_q;
        cli_out_d    = cli_out_q;
        cli_err_d    = cli_err_q;
`ifdef FLOAT_MUL_ARB_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    mul_req_d = 1'b1;
                    mul_a_d   = cli_a[int'(arb_grant)*float_width +: float_width];
                    mul_b_d   = cli_b[int'(arb_grant)*float_width +: float_width];
                    grant_d   = arb_grant;
                    state_d   = WAIT;
`ifdef FLOAT_MUL_ARB_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            WAIT: begin
`ifdef FLOAT_MUL_ARB_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
                if (mul_ack) begin
                    cli_out_d          = mul_out;
                    cli_ack_d          = '0;
                    cli_ack_d[grant_q] = 1'b1;
                    cli_err_d          = 1'b0;
                    last_grant_d       = grant_q;
                    state_d            = DONE;
                end
`ifdef FLOAT_MUL_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    cli_out_d          = '0;
                    cli_ack_d          = '0;
                    cli_ack_d[grant_q] = 1'b1;
                    cli_err_d          = 1'b1;
                    last_grant_d       = grant_q;
                    state_d            = DONE;
                end
`endif
            end
            DONE: begin
                // Spending this cycle lets the served client's dropped req settle before re-arbitration.
                cli_ack_d = '0;
                cli_out_d = '0;
                cli_err_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cli_ack = cli_ack_q;
    assign cli_out = cli_out_q;
    assign cli_err = cli_err_q;
    assign mul_req = mul_req_q;
    assign mul_a   = mul_a_q;
    assign mul_b   = mul_b_q;

endmodule

// File: tb/tb_float_mul_arbiter.sv
// Directed bench for float_mul_arbiter; the bench plays the multiplier with hand-computed products.
module tb_float_mul_arbiter;

    localparam int N  = 4;
    localparam int FW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    cli_req;
    logic [N*FW-1:0] cli_a;
    logic [N*FW-1:0] cli_b;
    logic [N-1:0]    cli_ack;
    logic [FW-1:0]   cli_out;
    logic            cli_err;
    logic            mul_req;
    logic [FW-1:0]   mul_a;
    logic [FW-1:0]   mul_b;
    logic            mul_ack;
    logic [FW-1:0]   mul_out;

    int total = 0;
    int bad   = 0;

    float_mul_arbiter #(
        .NUM_CLIENTS    (N),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cli_req (cli_req),
        .cli_a   (cli_a),
        .cli_b   (cli_b),
        .cli_ack (cli_ack),
        .cli_out (cli_out),
        .cli_err (cli_err),
        .mul_req (mul_req),
        .mul_a   (mul_a),
        .mul_b   (mul_b),
        .mul_ack (mul_ack),
        .mul_out (mul_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp_v);
        end
    endtask

    task automatic set_cli(input int k, input logic [31:0] a, input logic [31:0] b);
        cli_a[k*FW +: FW] = a;
        cli_b[k*FW +: FW] = b;
        cli_req[k]        = 1'b1;
    endtask

    // Entered at the negedge right after the grant edge; returns in IDLE after the DONE edge.
    task automatic serve(input int k, input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
        chk("grant_mul_req", {31'b0, mul_req}, 32'd1);
        chk("grant_mul_a", mul_a, a);
        chk("grant_mul_b", mul_b, b);
        tick();
        chk("mul_req_pulse_end", {31'b0, mul_req}, 32'd0);
        chk("mul_a_hold", mul_a, a);
        chk("no_early_ack", {28'b0, cli_ack}, 32'd0);
        mul_ack = 1'b1;
        mul_out = p;
        tick();
        chk("ack_onehot", {28'b0, cli_ack}, 32'(1 << k));
        chk("ack_out", cli_out, p);
        chk("ack_err", {31'b0, cli_err}, 32'd0);
        mul_ack    = 1'b0;
        cli_req[k] = 1'b0;
        tick();
        chk("ack_clear", {28'b0, cli_ack}, 32'd0);
        chk("out_clear", cli_out, 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        cli_req = '0;
        cli_a   = '0;
        cli_b   = '0;
        mul_ack = 1'b0;
        mul_out = '0;
        tick();
        tick();
        chk("rst_cli_ack", {28'b0, cli_ack}, 32'd0);
        chk("rst_cli_out", cli_out, 32'd0);
        chk("rst_mul_req", {31'b0, mul_req}, 32'd0);
        chk("rst_mul_a", mul_a, 32'd0);
        rst = 1'b0;
        tick();

        // Single client: 1.5 * 2.0 = 3.0
        set_cli(1, 32'h3FC00000, 32'h40000000);
        tick();
        serve(1, 32'h3FC00000, 32'h40000000, 32'h40400000);

        // Stray multiplier acks in IDLE must not produce a client ack.
        mul_ack = 1'b1;
        mul_out = 32'h12345678;
        tick();
        chk("idle_ack_ignored", {28'b0, cli_ack}, 32'd0);
        chk("idle_no_mul_req", {31'b0, mul_req}, 32'd0);
        mul_ack = 1'b0;

        // Fresh reset so rotation restarts at client 0; 2.0 * 3.0 = 6.0 for all.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < N; k++) set_cli(k, 32'h40000000, 32'h40400000);
        for (int k = 0; k < N; k++) begin
            tick();
            serve(k, 32'h40000000, 32'h40400000, 32'h40C00000);
        end

        // Grant client 2 (4.0*0.5=2.0), then 0 and 3 contend: 3 (3*3=9) wins before 0 (1*2=2).
        set_cli(2, 32'h40800000, 32'h3F000000);
        tick();
        serve(2, 32'h40800000, 32'h3F000000, 32'h40000000);
        set_cli(0, 32'h3F800000, 32'h40000000);
        set_cli(3, 32'h40400000, 32'h40400000);
        tick();
        serve(3, 32'h40400000, 32'h40400000, 32'h41100000);
        tick();
        serve(0, 32'h3F800000, 32'h40000000, 32'h40000000);

        // Zero operand: 0.0 * 1.0 = 0.0
        set_cli(0, 32'h00000000, 32'h3F800000);
        tick();
        serve(0, 32'h00000000, 32'h3F800000, 32'h00000000);

        // Reset in WAIT clears outputs asynchronously, then client 2 is served: 5.0*2.0=10.0
        set_cli(1, 32'h40400000, 32'h40000000);
        tick();
        chk("pre_rst_mul_req", {31'b0, mul_req}, 32'd1);
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_mul_a", mul_a, 32'd0);
        chk("mid_rst_mul_req", {31'b0, mul_req}, 32'd0);
        chk("mid_rst_cli_ack", {28'b0, cli_ack}, 32'd0);
        tick();
        rst     = 1'b0;
        cli_req = '0;
        set_cli(2, 32'h40A00000, 32'h40000000);
        tick();
        serve(2, 32'h40A00000, 32'h40000000, 32'h41200000);

`ifdef FLOAT_MUL_ARB_TIMEOUT_EN
        // No multiplier ack: timeout after 8 WAIT cycles, then a late ack is ignored.
        set_cli(3, 32'h3F800000, 32'h3F800000);
        tick();
        chk("tmo_mul_req", {31'b0, mul_req}, 32'd1);
        for (int i = 0; i < 7; i++) tick();
        chk("tmo_not_yet", {28'b0, cli_ack}, 32'd0);
        tick();
        chk("tmo_ack", {28'b0, cli_ack}, 32'h8);
        chk("tmo_err", {31'b0, cli_err}, 32'd1);
        chk("tmo_out", cli_out, 32'd0);
        cli_req = '0;
        mul_ack = 1'b1;
        mul_out = 32'h3F800000;
        tick();
        chk("tmo_done_clear", {28'b0, cli_ack}, 32'd0);
        chk("tmo_err_clear", {31'b0, cli_err}, 32'd0);
        tick();
        chk("late_ack_ignored", {28'b0, cli_ack}, 32'd0);
        mul_ack = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
